// File: rtl/if_id_skid_reg_pkg.sv
// Shared definitions for the IF/ID skid register: skid states, NOP encoding and MIPS field positions.
package if_id_skid_reg_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  localparam logic [31:0] NopInstr = 32'h0000_0000;
  localparam int unsigned PcStep   = 4;

  localparam int unsigned OpLsb    = 26;
  localparam int unsigned RsLsb    = 21;
  localparam int unsigned RtLsb    = 16;
  localparam int unsigned RdLsb    = 11;
  localparam int unsigned ShamtLsb = 6;

endpackage

// File: rtl/if_id_perf_cnt.sv
// Three saturating event counters for the IF/ID boundary (stall, bubble, flush cycles).
module if_id_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_stall,
  input  logic             inc_bubble,
  input  logic             inc_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (inc_stall && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (inc_bubble && bubble_q != '1) bubble_q <= bubble_q + 1'b1;
      if (inc_flush && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, stall and flush, and pre-split MIPS fields.
// Optional perf counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic               id_stall,
  input  logic               id_flush,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc4,
  output logic [5:0]         id_op,
  output logic [5:0]         id_funct,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic [4:0]         id_rd,
  output logic [4:0]         id_shamt,
  output logic [15:0]        id_imm16,
  output logic [25:0]        id_instr_index
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  skid_state_e        state_q, state_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic               accept, consume;

  // Handshake depends only on registered state, so the IFU never sees a comb path from decode.
  assign if_ready = (state_q != StTwo);
  assign id_valid = (state_q != StEmpty);
  assign accept   = if_valid & if_ready;
  assign consume  = id_valid & ~id_stall;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (id_flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d      = StOne;
            head_instr_d = if_instr;
            head_pc_d    = if_pc;
          end
        end
        StOne: begin
          if (accept && consume) begin
            head_instr_d = if_instr;
            head_pc_d    = if_pc;
          end else if (accept) begin
            state_d      = StTwo;
            skid_instr_d = if_instr;
            skid_pc_d    = if_pc;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (consume) begin
            state_d      = StOne;
            head_instr_d = skid_instr_q;
            head_pc_d    = skid_pc_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign id_instr       = id_valid ? head_instr_q : INSTR_W'(NopInstr);
  assign id_pc          = id_valid ? head_pc_q : '0;
  assign id_pc4         = id_pc + PC_W'(PcStep);
  assign id_op          = id_instr[OpLsb+5:OpLsb];
  assign id_rs          = id_instr[RsLsb+4:RsLsb];
  assign id_rt          = id_instr[RtLsb+4:RtLsb];
  assign id_rd          = id_instr[RdLsb+4:RdLsb];
  assign id_shamt       = id_instr[ShamtLsb+4:ShamtLsb];
  assign id_funct       = id_instr[5:0];
  assign id_imm16       = id_instr[15:0];
  assign id_instr_index = id_instr[25:0];

`ifdef IF_ID_PERF_CNT_EN
  if_id_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc_stall (id_valid & id_stall),
    .inc_bubble(~id_valid),
    .inc_flush (id_flush),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: queue-based reference model plus directed literal checks.
module tb_if_id_skid_reg;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [INSTR_W-1:0] if_instr = '0;
  logic [PC_W-1:0]    if_pc = '0;
  logic               if_valid = 1'b0;
  logic               if_ready;
  logic               id_stall = 1'b0;
  logic               id_flush = 1'b0;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc, id_pc4;
  logic [5:0]         id_op, id_funct;
  logic [4:0]         id_rs, id_rt, id_rd, id_shamt;
  logic [15:0]        id_imm16;
  logic [25:0]        id_instr_index;
`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0]   stall_cnt, bubble_cnt, flush_cnt;
  logic [CNT_W-1:0]   m_stall = '0, m_bubble = '0, m_flush = '0;
`endif

  if_id_skid_reg #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .id_stall      (id_stall),
    .id_flush      (id_flush),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .id_op         (id_op),
    .id_funct      (id_funct),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_shamt      (id_shamt),
    .id_imm16      (id_imm16),
    .id_instr_index(id_instr_index)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted entries, capacity two, head is what decode sees.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;
  entry_t q[$];

  always @(posedge clk or negedge reset) begin : model
    bit m_ready, m_valid;
    if (!reset) begin
      q.delete();
`ifdef IF_ID_PERF_CNT_EN
      m_stall = '0; m_bubble = '0; m_flush = '0;
`endif
    end else begin
      m_ready = (q.size() < 2);
      m_valid = (q.size() > 0);
`ifdef IF_ID_PERF_CNT_EN
      if (m_valid && id_stall && m_stall != '1) m_stall = m_stall + 1;
      if (!m_valid && m_bubble != '1) m_bubble = m_bubble + 1;
      if (id_flush && m_flush != '1) m_flush = m_flush + 1;
`endif
      if (id_flush) begin
        q.delete();
      end else begin
        if (m_valid && !id_stall) void'(q.pop_front());
        if (if_valid && m_ready) q.push_back(entry_t'({if_instr, if_pc}));
      end
    end
  end

  entry_t e;
  bit     e_valid;
  always @(negedge clk) begin : compare
    e_valid = (q.size() > 0);
    e = e_valid ? q[0] : '0;
    check("id_valid", id_valid, e_valid);
    check("if_ready", if_ready, q.size() < 2);
    check("id_instr", id_instr, e.instr);
    check("id_pc", id_pc, e.pc);
    check("id_pc4", id_pc4, PC_W'(e.pc + 32'd4));
    check("id_op", id_op, e.instr[31:26]);
    check("id_rs", id_rs, e.instr[25:21]);
    check("id_rt", id_rt, e.instr[20:16]);
    check("id_rd", id_rd, e.instr[15:11]);
    check("id_shamt", id_shamt, e.instr[10:6]);
    check("id_funct", id_funct, e.instr[5:0]);
    check("id_imm16", id_imm16, e.instr[15:0]);
    check("id_instr_index", id_instr_index, e.instr[25:0]);
`ifdef IF_ID_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("bubble_cnt", bubble_cnt, m_bubble);
    check("flush_cnt", flush_cnt, m_flush);
`endif
  end

  // Hold one set of inputs across one rising edge, then settle just past it.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic stall, input logic flush);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
    id_stall = stall;
    id_flush = flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_if_ready", if_ready, 1'b1);
    check("rst_id_pc4", id_pc4, 32'd4);
    @(posedge clk);
    #1 reset = 1'b1;

    // Top-of-memory PC wraps, then three stall cycles on a live entry.
    cyc(1'b1, 32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0);
    check("wrap_pc4", id_pc4, 32'h0);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IF_ID_PERF_CNT_EN
    check("stall_cnt3", stall_cnt, 32'd3);
`endif
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("drain_valid", id_valid, 1'b0);

    // Back-to-back stream with no stall.
    cyc(1'b1, 32'h3000, 32'h0111_0001, 1'b0, 1'b0);
    check("s_pc0", id_pc, 32'h3000);
    cyc(1'b1, 32'h3004, 32'h0111_0002, 1'b0, 1'b0);
    check("s_pc1", id_pc, 32'h3004);
    check("s_v1", id_valid, 1'b1);
    cyc(1'b1, 32'h3008, 32'h0111_0003, 1'b0, 1'b0);
    check("s_pc2", id_pc, 32'h3008);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("s_empty", id_valid, 1'b0);

    // Stall fills the skid entry; release drains in acceptance order.
    cyc(1'b1, 32'h3000, 32'h0222_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h3004, 32'h0222_0002, 1'b1, 1'b0);
    check("two_ready", if_ready, 1'b0);
    cyc(1'b1, 32'h3008, 32'h0222_0003, 1'b1, 1'b0);
    cyc(1'b1, 32'h3008, 32'h0222_0003, 1'b1, 1'b0);
    check("two_head", id_pc, 32'h3000);
    cyc(1'b1, 32'h3008, 32'h0222_0003, 1'b0, 1'b0);
    check("rel_pc1", id_pc, 32'h3004);
    cyc(1'b1, 32'h3008, 32'h0222_0003, 1'b0, 1'b0);
    check("rel_pc2", id_pc, 32'h3008);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush from TWO drops everything, including the same-cycle offer.
    cyc(1'b1, 32'h3000, 32'h0333_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h3004, 32'h0333_0002, 1'b1, 1'b0);
    cyc(1'b1, 32'h3008, 32'h0333_0003, 1'b1, 1'b1);
    check("fl_valid", id_valid, 1'b0);
    check("fl_ready", if_ready, 1'b1);
    cyc(1'b1, 32'h4000, 32'h0333_0004, 1'b0, 1'b0);
    check("fl_next", id_pc, 32'h4000);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // jal field split.
    cyc(1'b1, 32'h5000, 32'h0C00_0C01, 1'b0, 1'b0);
    check("jal_op", id_op, 6'h03);
    check("jal_index", id_instr_index, 26'h000_0C01);
    check("jal_imm", id_imm16, 16'h0C01);
    check("jal_rd", id_rd, 5'h01);
    check("jal_shamt", id_shamt, 5'h10);
    check("jal_funct", id_funct, 6'h01);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while TWO is held.
    cyc(1'b1, 32'h6000, 32'h0444_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h6004, 32'h0444_0002, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", id_valid, 1'b0);
    check("ar_ready", if_ready, 1'b1);
    check("ar_instr", id_instr, 32'h0);
    check("ar_pc4", id_pc4, 32'd4);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
